sp_mem_arbiter: RTL and testbench
=================================

// Module: sp_mem_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-latency RAM (M, L or P store of the shortest-path
//  engine) between two requesters: R0 = shortest-path engine, R1 = host loader/readback.
//  Per-access Req/Gnt handshake, round-robin fairness, and a Lock for multi-access
//  sequences (e.g. read L[up] then L[left]). A burst cap prevents starvation.
//  One instance sits in front of each of the three memories.
// PARAMETERS
//  D_WIDTH    8    data width (matches `D_WIDTH)
//  A_WIDTH    13   address width (matches `A_WIDTH)
//  MAX_BURST  4    max consecutive locked grants while the other requester waits (>=1)
// PORTS
//  Clk       in   1        rising-edge clock
//  Rst       in   1        asynchronous, active-low reset
//  Req0/Req1 in   1        access request, held until Gnt seen
//  Lock0/1   in   1        keep grant for next access (valid with Req)
//  Rw0/Rw1   in   1        1 = write, 0 = read
//  Addr0/1   in   A_WIDTH  access address
//  WData0/1  in   D_WIDTH  write data
//  Gnt0/Gnt1 out  1        1-cycle pulse: access issued this cycle
//  RValid0/1 out  1        read data valid on RData this cycle
//  RData     out  D_WIDTH  shared read data (= Mem_In)
//  Mem_En    out  1        RAM enable
//  Mem_Rw    out  1        RAM write strobe
//  Mem_Addr  out  A_WIDTH  RAM address
//  Mem_Out   out  D_WIDTH  RAM write data
//  Mem_In    in   D_WIDTH  RAM read data, valid 1 cycle after read issue
// BEHAVIOUR
//  - Reset (Rst=0, async): Gnt*, RValid*, Mem_En, Mem_Rw = 0; Mem_Addr, Mem_Out = 0;
//    Owner = NONE; Last = R1 (R0 wins first tie); BurstCnt = 0. In-flight read discarded.
//  - Access sampled at edge E from Req/Rw/Addr/WData of cycle before E. At E the
//    arbiter registers Gnt_x=1 and Mem_* from the winner; Mem_En=1 only when some Gnt.
//    Requester sees Gnt in cycle after E; it drops Req or presents next access then.
//    Req still high in the Gnt cycle = new request (back-to-back, 1 access/cycle).
//  - Read: RValid_x=1 exactly one cycle after Gnt_x with Rw=0; RData = Mem_In.
//    Writes never raise RValid.
//  - FSM (Owner): IDLE, OWN0, OWN1.
//    IDLE: no Req -> IDLE. One Req -> grant it. Both -> grant !Last.
//    OWNx (previous grant to x with Lock_x=1): if Req_x & (BurstCnt<MAX_BURST | !Req_y)
//    -> grant x, BurstCnt++ (saturating); else fall to round-robin as IDLE.
//    Grant without Lock -> Owner=IDLE, BurstCnt=0. Lock released -> IDLE next decision.
//  - BurstCnt counts grants since lock acquisition (first locked grant =1); reset on
//    owner change or lock release. Cap applies only while other requester is waiting.
//  - Last updated on every grant. Gnt0 & Gnt1 never both 1 (assert).
//  - Lock without Req ignored; Req drop while owner -> release.
//  - Addr passes through unmodified; no wrap or range check (engine limits to `MAX).
// STRUCTURE
//  - Package sp_defs: D_WIDTH, A_WIDTH, MAX, SIZE_ROW, P codes Start/Right/Down,
//    owner encoding (IDLE/OWN0/OWN1).
//  - Sub-module sp_arb_pick: combinational 2-way pick (Req, Lock, Owner, Last,
//    BurstCnt -> winner); top holds registers, Mem_* mux, RValid pipe.
// TESTING
//  - Reset: Rst=0 mid-read -> all outputs 0 async, no RValid after release.
//  - R0 alone reads Addr 0x005, Mem_In=0x2A -> Gnt0 at E+1, RValid0 & RData=0x2A at E+2.
//  - Req0=Req1=1 held, no Lock -> Gnt0,Gnt1,Gnt0,Gnt1 alternating, 1 grant/cycle.
//  - R0 Lock0=1 for 6 accesses, Req1 high, MAX_BURST=4 -> 4 Gnt0, then Gnt1, then R0.
//  - R0 locked, Req1=0 -> 10 consecutive Gnt0 (no cap); Req1 rises -> cap applies.
//  - R1 write 0x1FFF/0x08 then R0 read 0x1FFF -> Mem_Rw=1 first; RValid0 data 0x08.

Source files
------------

// File: rtl/sp_mem_arbiter_pkg.sv
// sp_mem_arbiter_pkg: shared widths, engine codes and owner encoding for the memory arbiter
package sp_mem_arbiter_pkg;
  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 13;
  localparam int SIZE_ROW = 64;
  localparam int MAX = SIZE_ROW * SIZE_ROW - 1;
  typedef enum logic [1:0] {P_START = 2'd0, P_RIGHT = 2'd1, P_DOWN = 2'd2} p_code_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
endpackage

// File: rtl/sp_mem_arbiter_if.sv
// sp_mem_arbiter_if: requester handshakes plus RAM port of one arbitrated memory
interface sp_mem_arbiter_if;
  import sp_mem_arbiter_pkg::*;
  logic req0, lock0, rw0, gnt0, rvalid0;
  logic req1, lock1, rw1, gnt1, rvalid1;
  logic [A_WIDTH-1:0] addr0, addr1, mem_addr;
  logic [D_WIDTH-1:0] wdata0, wdata1, rdata, mem_out, mem_in;
  logic mem_en, mem_rw;
  modport master (
    output req0, lock0, rw0, addr0, wdata0, req1, lock1, rw1, addr1, wdata1, mem_in,
    input gnt0, rvalid0, gnt1, rvalid1, rdata, mem_en, mem_rw, mem_addr, mem_out
  );
  modport slave (
    input req0, lock0, rw0, addr0, wdata0, req1, lock1, rw1, addr1, wdata1, mem_in,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, mem_en, mem_rw, mem_addr, mem_out
  );
endinterface

// File: rtl/sp_mem_arbiter_pick.sv
// sp_mem_arbiter_pick: combinational two-way winner selection with lock ownership and burst cap
module sp_mem_arbiter_pick import sp_mem_arbiter_pkg::*; #(
  parameter int MAX_BURST = 4,
  parameter int BW = 3
) (
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    owner,
  input  logic          last,
  input  logic [BW-1:0] burst_cnt,
  output logic          any,
  output logic          win
);
  logic own0, own1;
  assign own0 = owner == OWN0 && req0 && (burst_cnt < BW'(MAX_BURST) || !req1);
  assign own1 = owner == OWN1 && req1 && (burst_cnt < BW'(MAX_BURST) || !req0);
  assign any = req0 | req1;
  assign win = own0 ? 1'b0 : own1 ? 1'b1 : (req0 && req1) ? !last : req1;
endmodule

// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: shares one single-port 1-cycle RAM between two requesters with lock and fairness
module sp_mem_arbiter import sp_mem_arbiter_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input logic Clk,
  input logic Rst,
  sp_mem_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [1:0] owner;
  logic last, any, win, lock_w, cont;
  logic [BW-1:0] burst_cnt;
  sp_mem_arbiter_pick #(.MAX_BURST(MAX_BURST), .BW(BW)) u_pick (
    .req0(bus.req0), .req1(bus.req1), .owner(owner), .last(last),
    .burst_cnt(burst_cnt), .any(any), .win(win)
  );
  assign lock_w = win ? bus.lock1 : bus.lock0;
  assign cont = owner == (win ? OWN1 : OWN0);
  assign bus.rdata = bus.mem_in;
  // issue the winning access to the RAM, track ownership/burst, and pipe read-valid one cycle
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_rw <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_out <= '0;
      owner <= IDLE;
      last <= 1'b1;
      burst_cnt <= '0;
    end else begin
      bus.gnt0 <= any & !win;
      bus.gnt1 <= any & win;
      bus.rvalid0 <= bus.gnt0 & !bus.mem_rw;
      bus.rvalid1 <= bus.gnt1 & !bus.mem_rw;
      bus.mem_en <= any;
      bus.mem_rw <= any & (win ? bus.rw1 : bus.rw0);
      bus.mem_addr <= win ? bus.addr1 : bus.addr0;
      bus.mem_out <= win ? bus.wdata1 : bus.wdata0;
      if (any) last <= win;
      owner <= (any & lock_w) ? (win ? OWN1 : OWN0) : IDLE;
      burst_cnt <= !(any & lock_w) ? '0 : !cont ? BW'(1) :
                   burst_cnt == BW'(MAX_BURST) ? burst_cnt : burst_cnt + 1'b1;
    end
  a_one_gnt: assert property (@(posedge Clk) disable iff (!Rst) !(bus.gnt0 && bus.gnt1));
endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb_sp_mem_arbiter: directed vector table plus lock/burst/reset sequences for the arbiter
module tb_sp_mem_arbiter;
  import sp_mem_arbiter_pkg::*;
  typedef struct {
    logic [2:0] c0;
    logic [A_WIDTH-1:0] a0;
    logic [D_WIDTH-1:0] d0;
    logic [2:0] c1;
    logic [A_WIDTH-1:0] a1;
    logic [D_WIDTH-1:0] d1;
    logic [3:0] f;
    logic [D_WIDTH-1:0] rd;
    logic [1:0] m;
    logic [A_WIDTH-1:0] ma;
    logic [D_WIDTH-1:0] mo;
  } vec_t;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [D_WIDTH-1:0] ram [0:(1<<A_WIDTH)-1];
  vec_t vecs [10];
  sp_mem_arbiter_if bus();
  sp_mem_arbiter #(.MAX_BURST(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  // single-port RAM with one cycle read latency
  always @(posedge Clk)
    if (bus.mem_en) begin
      if (bus.mem_rw) ram[bus.mem_addr] <= bus.mem_out;
      else bus.mem_in <= ram[bus.mem_addr];
    end
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask
  task automatic clear_inputs();
    {bus.req0, bus.lock0, bus.rw0} = 3'b000;
    {bus.req1, bus.lock1, bus.rw1} = 3'b000;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < (1 << A_WIDTH); i++) ram[i] = '0;
    ram[13'h005] = 8'h2A;
    ram[13'h010] = 8'h33;
    ram[13'h020] = 8'h77;
    vecs[0] = '{3'b100, 13'h005, 8'h00, 3'b000, 13'h000, 8'h00, 4'b1000, 8'h00, 2'b10, 13'h005, 8'h00};
    vecs[1] = '{3'b000, 13'h000, 8'h00, 3'b000, 13'h000, 8'h00, 4'b0010, 8'h2A, 2'b00, 13'h000, 8'h00};
    vecs[2] = '{3'b100, 13'h010, 8'h00, 3'b100, 13'h020, 8'h00, 4'b0100, 8'h00, 2'b10, 13'h020, 8'h00};
    vecs[3] = '{3'b100, 13'h010, 8'h00, 3'b100, 13'h020, 8'h00, 4'b1001, 8'h77, 2'b10, 13'h010, 8'h00};
    vecs[4] = '{3'b100, 13'h010, 8'h00, 3'b100, 13'h020, 8'h00, 4'b0110, 8'h33, 2'b10, 13'h020, 8'h00};
    vecs[5] = '{3'b100, 13'h010, 8'h00, 3'b100, 13'h020, 8'h00, 4'b1001, 8'h77, 2'b10, 13'h010, 8'h00};
    vecs[6] = '{3'b000, 13'h000, 8'h00, 3'b000, 13'h000, 8'h00, 4'b0010, 8'h33, 2'b00, 13'h000, 8'h00};
    vecs[7] = '{3'b000, 13'h000, 8'h00, 3'b101, 13'h1FFF, 8'h08, 4'b0100, 8'h00, 2'b11, 13'h1FFF, 8'h08};
    vecs[8] = '{3'b100, 13'h1FFF, 8'h00, 3'b000, 13'h000, 8'h00, 4'b1000, 8'h00, 2'b10, 13'h1FFF, 8'h00};
    vecs[9] = '{3'b000, 13'h000, 8'h00, 3'b000, 13'h000, 8'h00, 4'b0010, 8'h08, 2'b00, 13'h000, 8'h00};
    clear_inputs();
    #1;
    chk("rst_gnt0", 0, 32'(bus.gnt0), 32'(0));
    chk("rst_gnt1", 0, 32'(bus.gnt1), 32'(0));
    chk("rst_rvalid0", 0, 32'(bus.rvalid0), 32'(0));
    chk("rst_rvalid1", 0, 32'(bus.rvalid1), 32'(0));
    chk("rst_mem_en", 0, 32'(bus.mem_en), 32'(0));
    chk("rst_mem_rw", 0, 32'(bus.mem_rw), 32'(0));
    chk("rst_mem_addr", 0, 32'(bus.mem_addr), 32'(0));
    chk("rst_mem_out", 0, 32'(bus.mem_out), 32'(0));
    #11 Rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      {bus.req0, bus.lock0, bus.rw0} = vecs[i].c0;
      bus.addr0 = vecs[i].a0;
      bus.wdata0 = vecs[i].d0;
      {bus.req1, bus.lock1, bus.rw1} = vecs[i].c1;
      bus.addr1 = vecs[i].a1;
      bus.wdata1 = vecs[i].d1;
      tick();
      chk("vec_gnt0", i, 32'(bus.gnt0), 32'(vecs[i].f[3]));
      chk("vec_gnt1", i, 32'(bus.gnt1), 32'(vecs[i].f[2]));
      chk("vec_rvalid0", i, 32'(bus.rvalid0), 32'(vecs[i].f[1]));
      chk("vec_rvalid1", i, 32'(bus.rvalid1), 32'(vecs[i].f[0]));
      chk("vec_mem_en", i, 32'(bus.mem_en), 32'(vecs[i].m[1]));
      if (vecs[i].m[1]) begin
        chk("vec_mem_rw", i, 32'(bus.mem_rw), 32'(vecs[i].m[0]));
        chk("vec_mem_addr", i, 32'(bus.mem_addr), 32'(vecs[i].ma));
      end
      if (vecs[i].m == 2'b11) chk("vec_mem_out", i, 32'(bus.mem_out), 32'(vecs[i].mo));
      if (vecs[i].f[1] | vecs[i].f[0]) chk("vec_rdata", i, 32'(bus.rdata), 32'(vecs[i].rd));
    end
    clear_inputs();
    bus.req1 = 1'b1;
    bus.addr1 = 13'h030;
    tick();
    chk("burst_pre_gnt1", 0, 32'(bus.gnt1), 32'(1));
    bus.req0 = 1'b1;
    bus.lock0 = 1'b1;
    bus.addr0 = 13'h040;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cap_gnt0", i, 32'(bus.gnt0), 32'(i != 4));
      chk("cap_gnt1", i, 32'(bus.gnt1), 32'(i == 4));
      if (i == 4) bus.req1 = 1'b0;
    end
    clear_inputs();
    tick();
    chk("cap_idle_en", 0, 32'(bus.mem_en), 32'(0));
    bus.req0 = 1'b1;
    bus.lock0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("nocap_gnt0", i, 32'(bus.gnt0), 32'(i != 10));
      chk("nocap_gnt1", i, 32'(bus.gnt1), 32'(i == 10));
      if (i == 9) bus.req1 = 1'b1;
      if (i == 10) bus.req1 = 1'b0;
    end
    clear_inputs();
    tick();
    bus.req0 = 1'b1;
    bus.addr0 = 13'h005;
    tick();
    chk("mid_gnt0", 0, 32'(bus.gnt0), 32'(1));
    bus.req0 = 1'b0;
    #2 Rst = 1'b0;
    #1;
    chk("arst_gnt0", 0, 32'(bus.gnt0), 32'(0));
    chk("arst_mem_en", 0, 32'(bus.mem_en), 32'(0));
    chk("arst_mem_addr", 0, 32'(bus.mem_addr), 32'(0));
    #2 Rst = 1'b1;
    tick();
    chk("arst_rvalid0", 0, 32'(bus.rvalid0), 32'(0));
    chk("arst_gnt0_after", 0, 32'(bus.gnt0), 32'(0));
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    chk("arst_tie_gnt0", 0, 32'(bus.gnt0), 32'(1));
    chk("arst_tie_gnt1", 0, 32'(bus.gnt1), 32'(0));
    clear_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
